// File: rtl/bayer_pattern_gen.sv
// ---------------------------------------------------------------------------
// bayer_pattern_gen
//
// Raw-pixel stream source for bring-up and simulation. Emits the same CCD
// style interface the greyscale converter consumes (X/Y, 12-bit raw data,
// data-valid, frame-valid) with programmable line and frame blanking, and a
// selectable deterministic pattern (ramp, Bayer bars, checker, constant).
//
// Ports
//   iCLK         clock, all logic on rising edge
//   iRST         synchronous active-high reset
//   iSTART       start continuous generation (only looked at while idle)
//   iSTOP        finish the current frame, then go idle
//   iMODE        pattern select, captured at each frame start
//   iCONST       constant pixel for mode 3, captured at each frame start
//   oX_Cont      column of current pixel (0 outside active video)
//   oY_Cont      line of current pixel (held through the line's blanking)
//   oDATA        raw pixel value
//   oDVAL        pixel valid
//   oFVAL        frame valid, first pixel through last pixel of frame
//   oBUSY        generator not idle
//   oFrame_Cont  completed-frame count, wraps
//
// The FSM counters describe the pixel being produced this cycle; every
// output is a register loaded from them, so the stream trails the FSM by
// exactly one cycle and no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module bayer_pattern_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 960,
    parameter int H_BLANK  = 16,
    parameter int V_BLANK  = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic        iSTOP,
    input  logic [1:0]  iMODE,
    input  logic [11:0] iCONST,
    output logic [10:0] oX_Cont,
    output logic [10:0] oY_Cont,
    output logic [11:0] oDATA,
    output logic        oDVAL,
    output logic        oFVAL,
    output logic        oBUSY,
    output logic [15:0] oFrame_Cont
);

    // Vertical blanking is a whole number of line times.
    localparam int VB_CYC  = V_BLANK * (H_ACTIVE + H_BLANK);
    localparam int CNT_MAX = (VB_CYC > H_BLANK) ? VB_CYC : H_BLANK;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] HB_LOAD = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] VB_LOAD = CW'(VB_CYC - 1);
    localparam logic [10:0]   X_LAST  = 11'(H_ACTIVE - 1);
    localparam logic [10:0]   Y_LAST  = 11'(V_ACTIVE - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [11:0] data;
        logic        dval;
        logic        fval;
    } pix_t;

    state_t      state;
    logic [10:0] x, y;
    logic [CW-1:0] cnt;
    logic        stop_pending;
    logic [1:0]  mode_q;
    logic [11:0] const_q;

    logic [11:0] pattern;
    pix_t        pix_d;

    always_comb begin
        pattern = 12'h000;
        case (mode_q)
            2'd0: pattern = {1'b0, x};
            2'd1: begin
                case ({y[0], x[0]})
                    2'b00:   pattern = 12'h800;  // G on R row
                    2'b01:   pattern = 12'hFFF;  // R
                    2'b10:   pattern = 12'h000;  // B
                    default: pattern = 12'h800;  // G on B row
                endcase
            end
            2'd2: pattern = (x[3] ^ y[3]) ? 12'hFFF : 12'h000;
            default: pattern = const_q;
        endcase
    end

    // Next output word from the FSM position. Y is held through the line's
    // own blanking; frame-valid drops in the blanking after the last line.
    always_comb begin
        pix_d = '0;
        case (state)
            ACTIVE: begin
                pix_d.x    = x;
                pix_d.y    = y;
                pix_d.data = pattern;
                pix_d.dval = 1'b1;
                pix_d.fval = 1'b1;
            end
            HBLANK: begin
                pix_d.y    = y;
                pix_d.fval = (y != Y_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state        <= IDLE;
            x            <= '0;
            y            <= '0;
            cnt          <= '0;
            stop_pending <= 1'b0;
            mode_q       <= '0;
            const_q      <= '0;
            oX_Cont      <= '0;
            oY_Cont      <= '0;
            oDATA        <= '0;
            oDVAL        <= 1'b0;
            oFVAL        <= 1'b0;
            oBUSY        <= 1'b0;
            oFrame_Cont  <= '0;
        end else begin
            oX_Cont <= pix_d.x;
            oY_Cont <= pix_d.y;
            oDATA   <= pix_d.data;
            oDVAL   <= pix_d.dval;
            oFVAL   <= pix_d.fval;
            oBUSY   <= (state != IDLE);

            // The last pixel is sitting on the outputs now; count it as done.
            if (oDVAL && oX_Cont == X_LAST && oY_Cont == Y_LAST)
                oFrame_Cont <= oFrame_Cont + 16'd1;

            stop_pending <= stop_pending | iSTOP;

            case (state)
                IDLE: begin
                    if (iSTART) begin
                        state   <= ACTIVE;
                        x       <= '0;
                        y       <= '0;
                        mode_q  <= iMODE;
                        const_q <= iCONST;
                    end
                end
                ACTIVE: begin
                    if (x == X_LAST) begin
                        state <= HBLANK;
                        cnt   <= HB_LOAD;
                    end else begin
                        x <= x + 11'd1;
                    end
                end
                HBLANK: begin
                    if (cnt == '0) begin
                        if (y == Y_LAST) begin
                            state <= VBLANK;
                            cnt   <= VB_LOAD;
                        end else begin
                            state <= ACTIVE;
                            x     <= '0;
                            y     <= y + 11'd1;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                VBLANK: begin
                    if (cnt == '0) begin
                        if (stop_pending) begin
                            state        <= IDLE;
                            stop_pending <= 1'b0;  // overrides the sticky set above
                        end else begin
                            state   <= ACTIVE;
                            x       <= '0;
                            y       <= '0;
                            mode_q  <= iMODE;
                            const_q <= iCONST;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bayer_pattern_gen.sv
module tb_bayer_pattern_gen;

    localparam int HA = 4, VA = 2, HB = 2, VB = 1;
    localparam int LINE = HA + HB;            // 6
    localparam int FRAME = LINE * (VA + VB);  // 18

    logic        clk, rst, start, stop;
    logic [1:0]  mode;
    logic [11:0] cst;
    logic [10:0] ox, oy;
    logic [11:0] odata;
    logic        odval, ofval, obusy;
    logic [15:0] ofc;

    bayer_pattern_gen #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB)) dut (
        .iCLK(clk), .iRST(rst), .iSTART(start), .iSTOP(stop), .iMODE(mode), .iCONST(cst),
        .oX_Cont(ox), .oY_Cont(oy), .oDATA(odata), .oDVAL(odval), .oFVAL(ofval),
        .oBUSY(obusy), .oFrame_Cont(ofc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    // Bayer tile indexed as row*2 + col, from the mosaic table.
    logic [11:0] bay [4] = '{12'h800, 12'hFFF, 12'h000, 12'h800};

    function automatic logic [11:0] pat(input logic [1:0] md, input int c, input int l,
                                        input logic [11:0] k);
        case (md)
            2'd0:    return 12'(c);
            2'd1:    return bay[(l % 2) * 2 + (c % 2)];
            2'd2:    return (((c / 8) + (l / 8)) % 2 == 1) ? 12'hFFF : 12'h000;
            default: return k;
        endcase
    endfunction

    // Timeline model: t counts output cycles since the first pixel of a run;
    // position in the frame follows from t modulo the line/frame periods.
    bit          started = 0;
    bit          m_on = 0, m_sp = 0;
    int          m_t = 0, m_fc = 0;
    logic [1:0]  m_mode = 0;
    logic [11:0] m_const = 0;
    int          ex_x, ex_y, ex_d, ex_fc;
    bit          ex_dv, ex_fv, ex_b;

    always @(posedge clk) begin
        int p, l, c;
        bit old_sp;
        started = 1;
        ex_x = 0; ex_y = 0; ex_d = 0; ex_dv = 0; ex_fv = 0; ex_b = 0;
        if (rst) begin
            m_on = 0; m_sp = 0; m_fc = 0;
        end else begin
            old_sp = m_sp;
            if (!m_on) begin
                if (start) begin
                    m_on = 1; m_t = -1; m_mode = mode; m_const = cst;
                end
                m_sp = m_sp | stop;
            end else begin
                m_t++;
                p = m_t % FRAME; l = p / LINE; c = p % LINE;
                if (p == LINE * (VA - 1) + HA) m_fc = (m_fc + 1) % 65536;
                ex_b = 1;
                if (l < VA) begin
                    ex_y = l;
                    if (c < HA) begin
                        ex_dv = 1; ex_fv = 1; ex_x = c; ex_d = pat(m_mode, c, l, m_const);
                    end else begin
                        ex_fv = (l < VA - 1);
                    end
                end
                if (p == FRAME - 1 && old_sp) begin
                    m_on = 0; m_sp = 0;
                end else begin
                    if (p == FRAME - 1) begin m_mode = mode; m_const = cst; end
                    m_sp = m_sp | stop;
                end
            end
        end
        ex_fc = m_fc;
    end

    always @(negedge clk) begin
        if (started) begin
            n_chk++;
            if (int'(ox) == ex_x && int'(oy) == ex_y && int'(odata) == ex_d && odval == ex_dv &&
                ofval == ex_fv && obusy == ex_b && int'(ofc) == ex_fc)
                n_pass++;
            else
                $display("FAIL model t=%0t got x=%0d y=%0d d=%0h dv=%0b fv=%0b b=%0b fc=%0d want x=%0d y=%0d d=%0h dv=%0b fv=%0b b=%0b fc=%0d",
                         $time, ox, oy, odata, odval, ofval, obusy, ofc,
                         ex_x, ex_y, ex_d, ex_dv, ex_fv, ex_b, ex_fc);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    int e;
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        e++;
    endtask
    task automatic go(input int n);
        while (e < n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int npix;
        logic [11:0] exp_b [8];
        exp_b = '{12'h800, 12'hFFF, 12'h800, 12'hFFF, 12'h000, 12'h800, 12'h000, 12'h800};

        rst = 1; start = 1; stop = 0; mode = 0; cst = 0; e = 0;
        repeat (3) tick();
        chk("reset dval", odval, 0);
        chk("reset busy", obusy, 0);
        chk("reset fval", ofval, 0);
        chk("reset fc", ofc, 0);

        // Mode 0 continuous, stop requested in line 1 of the second frame.
        rst = 0; e = -1; tick();
        chk("start busy lag", obusy, 0);
        start = 0;
        go(1);  chk("e1 dval", odval, 1); chk("e1 x", ox, 0); chk("e1 busy", obusy, 1);
        go(4);  chk("e4 x", ox, 3); chk("e4 data", odata, 3);
        go(5);  chk("e5 dval", odval, 0); chk("e5 fval", ofval, 1);
        go(7);  chk("e7 y", oy, 1); chk("e7 x", ox, 0);
        go(10); chk("e10 data", odata, 3);
        go(11); chk("e11 fc", ofc, 1); chk("e11 fval", ofval, 0);
        go(18); chk("e18 busy", obusy, 1);
        go(19); chk("e19 dval", odval, 1); chk("e19 y", oy, 0);
        go(26); stop = 1; tick(); stop = 0;
        go(29); chk("e29 fc", ofc, 2);
        go(36); chk("e36 busy", obusy, 1);
        go(37); chk("e37 busy", obusy, 0); chk("e37 fc", ofc, 2);
        go(45); chk("e45 dval", odval, 0);

        // Mode 1, start and stop together: one frame only.
        rst = 1; tick(); rst = 0;
        chk("rst2 fc", ofc, 0);
        mode = 1; start = 1; stop = 1; e = -1; tick();
        start = 0; stop = 0; npix = 0;
        while (e < 25) begin
            tick();
            if (odval) begin
                if (npix < 8) chk("bayer data", odata, exp_b[npix]);
                npix++;
            end
            if (e == 18) chk("one-shot e18 busy", obusy, 1);
            if (e == 19) chk("one-shot e19 busy", obusy, 0);
        end
        chk("one-shot pixels", npix, 8);
        chk("one-shot fc", ofc, 1);

        // Mode change mid-frame takes effect at next frame; stray start ignored.
        mode = 0; e = -1; start = 1; tick(); start = 0;
        go(2); mode = 3; cst = 12'hABC; start = 1; tick(); start = 0;
        go(3);  chk("ramp kept e3", odata, 2);
        go(8);  chk("ramp kept e8", odata, 1);
        go(19); chk("const e19", odata, 12'hABC);
        go(20); chk("const e20", odata, 12'hABC);
        rst = 1; tick(); rst = 0;
        chk("abort dval", odval, 0); chk("abort busy", obusy, 0);
        chk("abort x", ox, 0); chk("abort fc", ofc, 0);
        repeat (6) tick();

        #2;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
